// File: rtl/ps2_rx_port.sv
// PS/2 keyboard receiver: pin synchronizer, 11-bit frame FSM,
// scancode FIFO and DATA/STATUS bus registers.
module ps2_rx_port #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        sel,
  input  logic        addr,
  input  logic        rd,
  input  logic [3:0]  wenable,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic ck1_q, ck2_q, ck3_q;
  logic dt1_q, dt2_q;
  logic fall_q, bit_q;
  logic fall_d;

  state_t        state_q;
  logic [2:0]    cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q, fe_q;

  logic frame_end, frame_ok, tmo_hit;
  logic pop, push_ok, ovf_set, fe_set, clr;
  logic not_empty;
  logic unused_ok;

  assign fall_d = ck3_q & ~ck2_q;

  // Edge pulse and data bit are registered together so the FSM
  // samples both from the same stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck1_q  <= 1'b1;
      ck2_q  <= 1'b1;
      ck3_q  <= 1'b1;
      dt1_q  <= 1'b1;
      dt2_q  <= 1'b1;
      fall_q <= 1'b0;
      bit_q  <= 1'b1;
    end else begin
      ck1_q  <= ps2_clk;
      ck2_q  <= ck1_q;
      ck3_q  <= ck2_q;
      dt1_q  <= ps2_data;
      dt2_q  <= dt1_q;
      fall_q <= fall_d;
      bit_q  <= dt2_q;
    end
  end

  assign not_empty = (count_q != '0);
  assign frame_end = (state_q == ST_STOP) && fall_q;
  assign frame_ok  = frame_end && bit_q && ^{shift_q, par_q};
  assign tmo_hit   = (state_q != ST_IDLE) && !fall_q
                     && (tmo_q == TMO_C);

  assign pop     = sel & rd & ~addr & not_empty;
  assign push_ok = frame_ok & ((count_q != DEPTH_C) | pop);
  assign ovf_set = frame_ok & ~push_ok;
  assign fe_set  = (frame_end & ~frame_ok) | tmo_hit;
  assign clr     = sel & wenable[0] & addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      if (state_q == ST_IDLE || fall_q) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (fall_q && !bit_q) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
          end
        end
        ST_DATA: begin
          if (tmo_hit) begin
            state_q <= ST_IDLE;
          end else if (fall_q) begin
            shift_q <= {bit_q, shift_q[7:1]};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (tmo_hit) begin
            state_q <= ST_IDLE;
          end else if (fall_q) begin
            par_q   <= bit_q;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tmo_hit || fall_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // A set in the same cycle as a clear keeps the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clr && wdata[1]) begin
        ovf_q <= 1'b0;
      end
      if (fe_set) begin
        fe_q <= 1'b1;
      end else if (clr && wdata[2]) begin
        fe_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      !addr && not_empty: rdata = {24'b0, mem_q[rptr_q]};
      addr: rdata = {20'b0, 4'(count_q), 5'b0,
                     fe_q, ovf_q, not_empty};
      default: rdata = '0;
    endcase
  end

  assign irq = not_empty;

  assign unused_ok = ^{wenable[3:1], wdata[31:3], wdata[0]};

endmodule

// File: tb/tb_ps2_rx_port.sv
// Bench for ps2_rx_port: drives PS/2 frames on the pins and
// checks bus reads against a scancode queue model.
module tb_ps2_rx_port;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        sel = 1'b0;
  logic        addr = 1'b0;
  logic        rd = 1'b0;
  logic [3:0]  wenable = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int vec = 0;
  int mis = 0;
  logic [7:0] sbq[$];
  logic m_ovf = 1'b0;
  logic m_fe = 1'b0;

  ps2_rx_port #(
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .sel(sel),
    .addr(addr),
    .rd(rd),
    .wenable(wenable),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    return {20'b0, 4'(sbq.size()), 5'b0, m_fe, m_ovf,
            sbq.size() != 0};
  endfunction

  task automatic bus_rd(input logic a, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = a;
    #2;
    d = rdata;
    tick();
    sel = 1'b0; rd = 1'b0; addr = 1'b0;
  endtask

  task automatic bus_wr(input logic a, input logic [31:0] d);
    sel = 1'b1; wenable = 4'h1; addr = a; wdata = d;
    tick();
    sel = 1'b0; wenable = '0; addr = 1'b0; wdata = '0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp, input int nbits,
                            input bit pop, output logic i3,
                            output logic i4, output logic [31:0] rdv);
    logic [10:0] b;
    b = {stp, par, d, 1'b0};
    i3 = 1'b0; i4 = 1'b0; rdv = '0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      repeat (5) tick();
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) tick();
        i3 = irq;
        if (pop) begin
          sel = 1'b1; rd = 1'b1; addr = 1'b0;
          #2;
          rdv = rdata;
        end
        tick();
        sel = 1'b0; rd = 1'b0;
        i4 = irq;
        repeat (6) tick();
      end else begin
        repeat (10) tick();
      end
      ps2_clk = 1'b1;
      repeat (5) tick();
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d, input bit pop,
                           output logic [31:0] rdv,
                           output logic [31:0] erd,
                           output logic i3, output logic i4);
    erd = '0;
    send_frame(d, ~^d, 1'b1, 11, pop, i3, i4, rdv);
    if (pop && sbq.size() != 0) erd = {24'b0, sbq.pop_front()};
    if (sbq.size() < 8) sbq.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vec++;
    if (irq !== 1'b0) begin
      mis++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
    bus_rd(1'b0, d);
    vec++;
    if (d !== 32'h0) begin
      mis++; $display("FAIL reset_data got=%h exp=0", d);
    end
    bus_rd(1'b1, d);
    vec++;
    if (d !== 32'h0) begin
      mis++; $display("FAIL reset_status got=%h exp=0", d);
    end
  endtask

  task automatic test_good();
    logic [31:0] d, rdv, erd, e;
    logic i3, i4;
    send_good(8'h1C, 1'b0, rdv, erd, i3, i4);
    vec++;
    if (i3 !== 1'b0) begin
      mis++; $display("FAIL lat_edge3 got=%b exp=0", i3);
    end
    vec++;
    if (i4 !== 1'b1) begin
      mis++; $display("FAIL lat_edge4 got=%b exp=1", i4);
    end
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e || d !== 32'h101) begin
      mis++; $display("FAIL good_status got=%h exp=%h", d, e);
    end
    bus_rd(1'b0, d);
    e = {24'b0, sbq.pop_front()};
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL good_data got=%h exp=%h", d, e);
    end
    bus_rd(1'b1, d);
    vec++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      mis++; $display("FAIL good_drain got=%h irq=%b exp=0", d, irq);
    end
  endtask

  task automatic test_bad();
    logic [31:0] d, rdv, e;
    logic i3, i4;
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, i3, i4, rdv);
    m_fe = 1'b1;
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL bad_parity got=%h exp=%h", d, e);
    end
    bus_wr(1'b1, 32'h4);
    m_fe = 1'b0;
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL fe_clear got=%h exp=%h", d, e);
    end
    send_frame(8'hF0, 1'b1, 1'b0, 11, 1'b0, i3, i4, rdv);
    m_fe = 1'b1;
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL bad_stop got=%h exp=%h", d, e);
    end
    bus_wr(1'b1, 32'h4);
    m_fe = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d, rdv, erd, e;
    logic i3, i4;
    for (int k = 1; k <= 9; k++) begin
      send_good(8'(k), 1'b0, rdv, erd, i3, i4);
    end
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e || d !== 32'h803) begin
      mis++; $display("FAIL ovf_status got=%h exp=%h", d, e);
    end
    for (int k = 0; k < 9; k++) begin
      bus_rd(1'b0, d);
      e = (sbq.size() != 0) ? {24'b0, sbq.pop_front()} : 32'h0;
      vec++;
      if (d !== e) begin
        mis++; $display("FAIL ovf_read%0d got=%h exp=%h", k, d, e);
      end
    end
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL ovf_empty got=%h exp=%h", d, e);
    end
    bus_wr(1'b1, 32'h2);
    m_ovf = 1'b0;
  endtask

  task automatic test_collision();
    logic [31:0] d, rdv, erd, e;
    logic i3, i4;
    for (int k = 0; k < 8; k++) begin
      send_good(8'h10 + 8'(k), 1'b0, rdv, erd, i3, i4);
    end
    send_good(8'h18, 1'b1, rdv, erd, i3, i4);
    vec++;
    if (rdv !== erd) begin
      mis++; $display("FAIL coll_pop got=%h exp=%h", rdv, erd);
    end
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e || d !== 32'h801) begin
      mis++; $display("FAIL coll_status got=%h exp=%h", d, e);
    end
    for (int k = 0; k < 8; k++) begin
      bus_rd(1'b0, d);
      e = (sbq.size() != 0) ? {24'b0, sbq.pop_front()} : 32'h0;
      vec++;
      if (d !== e) begin
        mis++; $display("FAIL coll_read%0d got=%h exp=%h", k, d, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d, rdv, erd, e;
    logic i3, i4;
    send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0, i3, i4, rdv);
    repeat (TMO + 5) tick();
    m_fe = 1'b1;
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL timeout_fe got=%h exp=%h", d, e);
    end
    bus_wr(1'b1, 32'h4);
    m_fe = 1'b0;
    send_good(8'h5A, 1'b0, rdv, erd, i3, i4);
    bus_rd(1'b0, d);
    e = {24'b0, sbq.pop_front()};
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL timeout_next got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_reset_glitch();
    logic [31:0] d, rdv, erd, e;
    logic i3, i4;
    send_good(8'h33, 1'b0, rdv, erd, i3, i4);
    send_frame(8'h6C, 1'b0, 1'b1, 6, 1'b0, i3, i4, rdv);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    sbq.delete();
    m_fe = 1'b0;
    m_ovf = 1'b0;
    tick();
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e || irq !== 1'b0) begin
      mis++; $display("FAIL rst_mid got=%h irq=%b exp=%h", d, irq, e);
    end
    bus_rd(1'b0, d);
    vec++;
    if (d !== 32'h0) begin
      mis++; $display("FAIL rst_data got=%h exp=0", d);
    end
    ps2_data = 1'b1;
    repeat (5) tick();
    ps2_clk = 1'b0;
    repeat (10) tick();
    ps2_clk = 1'b1;
    repeat (10) tick();
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL glitch got=%h exp=%h", d, e);
    end
    send_good(8'h29, 1'b0, rdv, erd, i3, i4);
    bus_rd(1'b0, d);
    e = {24'b0, sbq.pop_front()};
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL post_glitch got=%h exp=%h", d, e);
    end
    bus_rd(1'b1, d);
    e = exp_status();
    vec++;
    if (d !== e) begin
      mis++; $display("FAIL final_status got=%h exp=%h", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad();
    test_overflow();
    test_collision();
    test_timeout();
    test_reset_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/ps2_rx_port.md
# ps2_rx_port

Memory-mapped PS/2 keyboard receiver: synchronizes the external `ps2_clk`/`ps2_data` lines, deserializes 11-bit device-to-host frames, validates them, and queues scancode bytes in a small FIFO. It is the input peripheral that feeds the CPU data bus.
- The CPU pops scancodes through a DATA register and polls or clears flags through a STATUS register.
- `irq` is level-high while bytes are pending.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: scancode queue depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a PS/2 falling edge before a partial frame is aborted.

Ports:
- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `sel` in 1: bus select; this peripheral is addressed.
- `addr` in 1: word index; 0 = DATA, 1 = STATUS.
- `rd` in 1: read strobe; qualified by `sel`.
- `wenable` in 4: byte write enables; a write occurs when `sel` is high and `|wenable` is true.
- `wdata` in 32: write data.
- `rdata` out 32: read data; combinational from `addr` and the current state.
- `irq` out 1: FIFO not empty.

## Operation
- **Synchronizer:** two flip-flops per pin, plus a third register on synchronized `ps2_clk` for edge detection.
  - `fall` = previous synchronized clock high AND current synchronized clock low.
  - All frame sampling uses synchronized `ps2_data` in cycles where `fall` is asserted.
- **Receive FSM:** states IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA, bit count 0, timeout counter 0. On `fall` with data=1, stay in IDLE (glitch) and set no flag.
  - DATA: on each `fall`, shift data into bit[count], LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, record the parity bit and go to STOP.
  - STOP: on `fall`, the frame is valid if the stop bit is 1 AND the 8 data bits plus parity contain an odd number of ones. A valid frame pushes the byte. An invalid frame discards it and sets `frame_err`. Either way, return to IDLE.
  - Timeout: in any non-IDLE state, the counter increments every cycle without `fall` and resets on `fall`. When it reaches `TIMEOUT_CYCLES`, go to IDLE and set `frame_err`.
- **FIFO:** circular buffer with read/write pointers and a count of width clog2(`FIFO_DEPTH`)+1.
  - A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
  - A pop occurs on `sel` & `rd` & `addr`=0 & count≠0. A pop on an empty FIFO does nothing.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- **Registers:**
  - DATA read: {24'b0, head byte}; 0 when empty.
  - STATUS read: {20'b0, count zero-extended to 4 bits in [11:8], 5'b0, `frame_err`[2], `overflow`[1], not_empty[0]}.
  - STATUS write with `wenable`[0] set: `wdata`[1]=1 clears `overflow` and `wdata`[2]=1 clears `frame_err` (write-1-to-clear).
  - If a set and a clear of the same flag happen in the same cycle, set wins.
  - Writes to DATA are ignored.
- `irq` = not_empty.

## Timing
- **Reset** (takes priority over everything):
  - FSM → IDLE; pointers, count and timeout counter → 0.
  - `overflow` and `frame_err` → 0.
  - Synchronizer registers → 1 (bus idle high).
  - Result: `irq`=0, and `rdata`=0 for both addresses.
- **Reset mid-frame:** the partial frame is discarded with no flag set. The next start bit begins a fresh frame.
- **Latency:** the raw stop-bit falling edge appears in `irq`/STATUS[0] after the 4th rising `clk` edge (2 sync stages + edge register + FSM/FIFO update).
- **Pop visibility:** a pop takes effect at the rising edge that ends the read cycle. `rdata` shows the next head in the following cycle.
- **Back-to-back frames:** frames separated by a single PS/2 bit time are accepted, since the FSM is in IDLE one cycle after the stop edge.
- **Flags:** `overflow` and `frame_err` are sticky until cleared or reset.

## Test plan
- **Good frame:** after reset, send start 0, data 0x1C LSB first, parity 0, stop 1 → `irq`=1, STATUS reads 0x101, DATA read returns 0x1C, then STATUS reads 0x000 and `irq`=0.
- **Bad parity / bad stop:** send data 0xF0 with parity 0 → no push, STATUS=0x004. Write STATUS 0x4 → STATUS=0x000. Send 0xF0 with parity 1 and stop 0 → STATUS=0x004.
- **Overflow:** send 9 valid frames 0x01..0x09 with no reads → STATUS=0x803. Eight DATA reads return 0x01..0x08 in order; a ninth read returns 0 with no pointer change.
- **Push/pop collision on full:** FIFO full at 8. A DATA read in exactly the cycle of the 9th frame's push → no overflow, count stays 8, and the last entry is the new byte.
- **Timeout:** send start + 4 data bits, then hold lines high for `TIMEOUT_CYCLES`+5 cycles → `frame_err`=1, FSM IDLE. A subsequent valid 0x5A frame is received correctly.
- **Reset and glitch:** assert `rst` after 6 bits of a frame → all outputs 0. Next, a lone falling edge with data=1 leaves STATUS=0x000. A valid 0x29 frame is then received correctly.
